// File: rtl/timer_pkg.sv
// Shared constants and helpers for the microsecond tick timer.
package timer_pkg;

  localparam int unsigned TIMER_1US_DEFAULT_PERIOD = 36;

  // Counter width for a modulus n: max(1, clog2(n)).
  function automatic int unsigned timer_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/timer_1us.sv
// Tick generator: q pulses for one cycle after every PERIOD enabled clock edges.
// Define TIMER_1US_ASSERT_EN to compile in concurrent checks on counter range and tick shape.
module timer_1us
  import timer_pkg::*;
#(
  parameter int unsigned PERIOD = TIMER_1US_DEFAULT_PERIOD
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic en,
  output logic q
);

  localparam int unsigned CW = timer_width(PERIOD);
  localparam logic [CW-1:0] CntLast = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  // Wrap is detected by equality with CntLast, so the counter never reaches PERIOD.
  always_comb begin
    cnt_d = cnt_q;
    q_d   = 1'b0;
    if (en) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        q_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

`ifdef TIMER_1US_ASSERT_EN
  if (PERIOD < 1) begin : g_bad_period
    $error("timer_1us: PERIOD must be at least 1");
  end

  a_cnt_range: assert property (@(posedge clk_36MHz) disable iff (reset)
    32'(cnt_q) < PERIOD);

  a_q_after_idle: assert property (@(posedge clk_36MHz) disable iff (reset)
    !en |=> !q_q);

  if (PERIOD > 1) begin : g_single_pulse
    a_q_one_cycle: assert property (@(posedge clk_36MHz) disable iff (reset)
      q_q |=> !q_q);
  end
`else
`endif

endmodule

// File: tb/tb_timer_1us.sv
// Randomized scoreboard bench for timer_1us at PERIOD = 1, 4, 5 and 8.
module tb_timer_1us;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic q1, q4, q5, q8;

  always #5 clk = ~clk;

  timer_1us #(.PERIOD(1)) u_p1 (.clk_36MHz(clk), .reset(reset), .en(en), .q(q1));
  timer_1us #(.PERIOD(4)) u_p4 (.clk_36MHz(clk), .reset(reset), .en(en), .q(q4));
  timer_1us #(.PERIOD(5)) u_p5 (.clk_36MHz(clk), .reset(reset), .en(en), .q(q5));
  timer_1us #(.PERIOD(8)) u_p8 (.clk_36MHz(clk), .reset(reset), .en(en), .q(q8));

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Expected {q8, q5, q4, q1} after each rising edge, oldest first.
  logic [3:0] exp_q[$];

  // Enabled edges seen since the last reset; a tick is due whenever it is a multiple of PERIOD.
  int unsigned ecnt = 0;

  task automatic check(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] model_edge(input logic en_v);
    if (en_v) ecnt++;
    return {en_v && (ecnt % 8 == 0), en_v && (ecnt % 5 == 0),
            en_v && (ecnt % 4 == 0), en_v && (ecnt % 1 == 0)};
  endfunction

  task automatic check_all_low(input string tag);
    check({tag, "_q1"}, q1, 1'b0);
    check({tag, "_q4"}, q4, 1'b0);
    check({tag, "_q5"}, q5, 1'b0);
    check({tag, "_q8"}, q8, 1'b0);
  endtask

  // One cycle of stimulus, optionally preceded by an asynchronous reset pulse between edges.
  task automatic drive(input logic en_v, input logic pulse);
    @(negedge clk);
    #1;
    if (pulse) begin
      reset = 1'b1;
      #1;
      check_all_low("async_reset");
      ecnt = 0;
      #1;
      reset = 1'b0;
    end
    en = en_v;
    exp_q.push_back(model_edge(en_v));
  endtask

  // Monitor: every falling edge after a scheduled rising edge, compare against the scoreboard.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tick_p1", q1, e[0]);
        check("tick_p4", q4, e[1]);
        check("tick_p5", q5, e[2]);
        check("tick_p8", q8, e[3]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    #1;
    check_all_low("reset_immediate");
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_low("reset_over_en");

    // Release and run with en held high.
    drive(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);

    // Alternating enable.
    drive(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) drive((i % 2) == 0, 1'b0);

    // Short enable drop: PERIOD=1 goes low exactly while en is low.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);

    // Reset mid-count discards the partial count.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
    end

    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_1us.md
TIMER_1US -- requirements
Module: timer_1us

Interface
REQ-001 Parameter PERIOD, default 36, number of enabled clock cycles per output tick (36 = 1 us at 36 MHz); legal range 1..2^24.
REQ-002 clk_36MHz  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  count enable; counter advances only on edges where en=1.
REQ-005 q  output  1  registered tick, high for exactly one cycle per elapsed PERIOD enabled cycles.

Function
REQ-006 Internal counter cnt SHALL be CW = max(1, $clog2(PERIOD)) bits wide, unsigned, range 0..PERIOD-1.
REQ-007 On a rising edge with en=1 and cnt==PERIOD-1: cnt SHALL become 0 and q SHALL become 1.
REQ-008 On a rising edge with en=1 and cnt<PERIOD-1: cnt SHALL increment by 1 and q SHALL become 0.
REQ-009 On a rising edge with en=0: cnt SHALL hold and q SHALL become 0; ticks are never lost or queued, and counting resumes from the held value.
REQ-010 Latency: with en held at 1 from reset release, q SHALL first be high in the cycle after the PERIOD-th rising edge, then every PERIOD cycles.
REQ-011 q SHALL be high for exactly one cycle per wrap, except PERIOD=1 with en held high, where q SHALL stay high continuously.
REQ-012 cnt SHALL never exceed PERIOD-1; no arithmetic overflow path SHALL exist, including when PERIOD is a power of two.
REQ-013 q SHALL be driven directly from a flop, with no combinational path from en or reset to q apart from the asynchronous clear.

Reset
REQ-014 While reset=1, cnt SHALL be 0 and q SHALL be 0, immediately and independently of the clock.
REQ-015 Reset asserted mid-count SHALL discard the partial count; after deassertion, the next tick SHALL occur a full PERIOD enabled cycles later.
REQ-016 Reset SHALL take priority over en on any edge where both are active.

Configuration
REQ-017 Macro TIMER_1US_ASSERT_EN, when defined, SHALL compile in concurrent assertions:
  - cnt<PERIOD at all times;
  - q is never high on two consecutive cycles when PERIOD>1;
  - q=0 in the cycle following any edge with en=0;
  - an elaboration error is raised if PERIOD<1.
REQ-018 Without TIMER_1US_ASSERT_EN, no assertion code SHALL be present, and RTL behaviour SHALL be identical with or without it.

Structure
REQ-019 Shared package timer_pkg SHALL hold constant TIMER_1US_DEFAULT_PERIOD=36 and a width function returning max(1, $clog2(n)).
REQ-020 The block SHALL be a single flat module with no sub-module; counter and tick flop are internal.

Verification
REQ-021 PERIOD=4, en=1 constant after reset release -> q high after edges 4, 8, 12, each for one cycle.
REQ-022 PERIOD=5, en toggled 1,0,1,0,… -> q high once per 5 enabled edges (every 10 clocks), and never on a cycle following an en=0 edge.
REQ-023 PERIOD=2000, reset pulsed asynchronously (between clock edges) at enabled cycle 1500 -> q stays 0; next tick 2000 enabled edges after release.
REQ-024 PERIOD=1, en=1 -> q continuously high; en dropped for 3 cycles -> q low exactly 3 cycles.
REQ-025 PERIOD=100000 (CW=17), en=1 for 300000 cycles -> exactly 3 ticks, spaced 100000 cycles apart; assertions enabled and none firing.
REQ-026 PERIOD=8 (power of two, CW=3) -> cnt wraps 7->0 with a tick, and no value of 8 is reachable.
